// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16 x 32-bit register bank write side.
package reg_bank_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef logic [NREGS-1:0][DATA_W-1:0] reg_arr_t;
endpackage

// File: rtl/reg_bank_writer_wr_decoder.sv
// Enable-gated one-hot decoder from a register index to per-register strobes.
module wr_decoder
  import reg_bank_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the 16 x 32-bit register bank: handshaked single writes plus a
// sequenced one-register-per-cycle bulk clear. Optional macro R0_ZERO_EN pins r0 to 0.
module reg_bank_writer
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ack_q, ack_d;
  reg_arr_t          regs_q, regs_d;

  logic              accept;
  logic              clr_active;
  logic [NREGS-1:0]  wr_en;
  logic [NREGS-1:0]  clr_en;

  assign accept     = wr_valid && wr_ready;
  assign clr_active = (state_q == ST_CLEAR);

  wr_decoder u_wr_dec (
    .en     (accept),
    .sel    (wr_sel),
    .onehot (wr_en)
  );

  wr_decoder u_clr_dec (
    .en     (clr_active),
    .sel    (cnt_q),
    .onehot (clr_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      regs_q  <= regs_d;
    end
  end

  // Counter wraps 15 -> 0 on the same edge that leaves ST_CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NREGS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // wr_ready is qualified by rst_n so no write can slip in while reset is held.
  always_comb begin
    wr_ready = rst_n && (state_q == ST_IDLE);
    clr_busy = clr_active;
    ack_d    = accept;
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (clr_en[i])     regs_d[i] = '0;
      else if (wr_en[i]) regs_d[i] = wr_data;
    end
`ifdef R0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  assign wr_ack = ack_q;

  assign r0  = regs_q[0];
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign r4  = regs_q[4];
  assign r5  = regs_q[5];
  assign r6  = regs_q[6];
  assign r7  = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: vector table, directed clear sequences,
// and randomized traffic against an abstract model (honours R0_ZERO_EN).
module tb_reg_bank_writer;

  logic        clk = 1'b0;
  logic        rst_n, wr_valid, wr_ready, wr_ack, clr_req, clr_busy;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] dr [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_bank_writer dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack), .clr_req(clr_req),
    .clr_busy(clr_busy),
    .r0(dr[0]), .r1(dr[1]), .r2(dr[2]), .r3(dr[3]), .r4(dr[4]), .r5(dr[5]),
    .r6(dr[6]), .r7(dr[7]), .r8(dr[8]), .r9(dr[9]), .r10(dr[10]), .r11(dr[11]),
    .r12(dr[12]), .r13(dr[13]), .r14(dr[14]), .r15(dr[15])
  );

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Abstract model: register contents, cycles of clearing still to run, ack pulse.
  logic [31:0] m_mem [16];
  int          m_clear_left;
  bit          m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int bad;
    bad = -1;
    chk("ack", 32'(wr_ack), 32'(m_ack));
    chk("busy", 32'(clr_busy), 32'(m_clear_left > 0));
    chk("ready", 32'(wr_ready), 32'(rst_n && m_clear_left == 0));
    for (int i = 0; i < 16; i++) if (dr[i] !== m_mem[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL regs: r%0d got %h expected %h at %0t", bad, dr[bad], m_mem[bad], $time);
    end
  endtask

  // One clock: drive after negedge, advance model across posedge, check 1ns later.
  task automatic tick(input bit rst, input bit v, input logic [3:0] sel,
                      input logic [31:0] data, input bit clr);
    @(negedge clk);
    rst_n = rst; wr_valid = v; wr_sel = sel; wr_data = data; clr_req = clr;
    @(posedge clk);
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_clear_left = 0;
      m_ack = 0;
    end else if (m_clear_left > 0) begin
      m_mem[16 - m_clear_left] = '0;
      m_clear_left--;
      m_ack = 0;
    end else begin
      m_ack = v;
      if (v && !(R0_ZERO && sel == 0)) m_mem[sel] = data;
      if (clr) m_clear_left = 16;
    end
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 4'd0, 32'd0, 0);
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [3:0]  sel;
    logic [31:0] data;
    bit          clr;
    bit          e_ack;
    bit          e_ready;
    bit          e_busy;
    int          ridx;
    logic [31:0] rval;
  } vec_t;

  vec_t tbl [10];

  initial begin
    rst_n = 0; wr_valid = 0; wr_sel = 0; wr_data = 0; clr_req = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    m_clear_left = 0;
    m_ack = 0;

    tbl[0] = '{0, 0, 4'd0,  32'h0,        0, 0, 0, 0, 5,  32'h0};
    tbl[1] = '{1, 1, 4'd5,  32'hDEADBEEF, 0, 1, 1, 0, 5,  32'hDEADBEEF};
    tbl[2] = '{1, 0, 4'd0,  32'h0,        0, 0, 1, 0, 4,  32'h0};
    tbl[3] = '{1, 1, 4'd3,  32'h1,        0, 1, 1, 0, 3,  32'h1};
    tbl[4] = '{1, 1, 4'd3,  32'h2,        0, 1, 1, 0, 3,  32'h2};
    tbl[5] = '{1, 1, 4'd15, 32'hFFFFFFFF, 0, 1, 1, 0, 15, 32'hFFFFFFFF};
    tbl[6] = '{1, 0, 4'd0,  32'h0,        0, 0, 1, 0, 3,  32'h2};
    tbl[7] = '{1, 1, 4'd0,  32'h1234,     0, 1, 1, 0, 0,  R0_ZERO ? 32'h0 : 32'h1234};
    tbl[8] = '{1, 0, 4'd0,  32'h0,        0, 0, 1, 0, 0,  R0_ZERO ? 32'h0 : 32'h1234};
    tbl[9] = '{1, 0, 4'd0,  32'h0,        0, 0, 1, 0, 5,  32'hDEADBEEF};

    tick(0, 0, 4'd0, 32'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].clr);
      chk($sformatf("vec%0d_ack", i), 32'(wr_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_busy", i), 32'(clr_busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_r%0d", i, tbl[i].ridx), dr[tbl[i].ridx], tbl[i].rval);
    end

    // Fill every register, then clear while a write is held pending.
    for (int k = 0; k < 16; k++) tick(1, 1, 4'(k), 32'(k + 100), 0);
    tick(1, 0, 4'd0, 32'd0, 1);
    chk("clr_start_busy", 32'(clr_busy), 32'd1);
    chk("clr_start_ready", 32'(wr_ready), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick(1, 1, 4'd2, 32'd77, 1);
      chk($sformatf("clr%0d_zeroed", k), dr[k - 1], 32'd0);
      if (k < 16) chk($sformatf("clr%0d_kept", k), dr[k], 32'(k + 100));
      chk($sformatf("clr%0d_ready", k), 32'(wr_ready), 32'(k == 16));
      chk($sformatf("clr%0d_ack", k), 32'(wr_ack), 32'd0);
    end
    tick(1, 1, 4'd2, 32'd77, 0);
    chk("held_write_ack", 32'(wr_ack), 32'd1);
    chk("held_write_r2", dr[2], 32'd77);

    // Write coinciding with clear request.
    tick(1, 1, 4'd7, 32'h55, 1);
    chk("simul_ack", 32'(wr_ack), 32'd1);
    chk("simul_r7", dr[7], 32'h55);
    idle(16);
    chk("simul_r7_cleared", dr[7], 32'd0);
    chk("simul_ready", 32'(wr_ready), 32'd1);

    // Reset in the middle of a clear.
    tick(1, 1, 4'd12, 32'hABCD, 0);
    tick(1, 0, 4'd0, 32'd0, 1);
    idle(6);
    tick(0, 1, 4'd9, 32'h99, 0);
    chk("midrst_busy", 32'(clr_busy), 32'd0);
    chk("midrst_r12", dr[12], 32'd0);
    tick(1, 0, 4'd0, 32'd0, 0);
    chk("midrst_ready", 32'(wr_ready), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(99) != 0), $urandom_range(1), 4'($urandom_range(15)),
           $urandom, ($urandom_range(24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
